// File: rtl/fetch_ifid_stage_if.sv
// Bus bundle between the fetch/IF-ID stage and its surroundings.
// It covers the hazard unit, the ID branch decision, instruction memory and the IF/ID outputs.
// The stage uses the master modport; the environment (ID stage, memory, bench) uses slave.
interface fetch_ifid_stage_if;
    logic        PC_write_en;
    logic        IFID_write_en;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] IFID_instr;
    logic [15:0] IFID_pc_plus2;
    logic        IFID_valid;
    logic        halted;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    modport master (
        input  PC_write_en,
        input  IFID_write_en,
        input  branch_taken,
        input  branch_target,
        input  imem_data,
        output imem_addr,
        output IFID_instr,
        output IFID_pc_plus2,
        output IFID_valid,
        output halted,
        output stall_count,
        output flush_count
    );

    modport slave (
        output PC_write_en,
        output IFID_write_en,
        output branch_taken,
        output branch_target,
        output imem_data,
        input  imem_addr,
        input  IFID_instr,
        input  IFID_pc_plus2,
        input  IFID_valid,
        input  halted,
        input  stall_count,
        input  flush_count
    );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch stage plus IF/ID pipeline register.
// It owns the PC, stops fetching on HLT, and counts stall cycles and taken-branch flushes.
// Every output is taken straight from a register, so nothing depends combinationally on an input.
module fetch_ifid_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    fetch_ifid_stage_if.master bus
);

    logic [15:0] pc_q,         pc_d;
    logic [15:0] instr_q,      instr_d;
    logic [15:0] pc_plus2_q,   pc_plus2_d;
    logic        valid_q,      valid_d;
    logic        halted_q,     halted_d;
    logic [15:0] stall_cnt_q,  stall_cnt_d;
    logic [15:0] flush_cnt_q,  flush_cnt_d;

    logic [15:0] pc_plus2;
    logic        is_hlt;
    logic        accept_br;

    // Next-state logic: priority is branch > stall > halt > normal fetch.
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_plus2_d  = pc_plus2_q;
        valid_d     = valid_q;
        halted_d    = halted_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        pc_plus2  = pc_q + 16'd2;
        is_hlt    = (bus.imem_data[15:12] == 4'hF) && !halted_q;
        // A branch seen while the PC is frozen is still unresolved in ID, so it is ignored.
        accept_br = bus.branch_taken && bus.PC_write_en;

        // The PC and halt flag advance only when the hazard unit lets the PC move.
        if (accept_br) begin
            pc_d     = bus.branch_target;
            halted_d = 1'b0;
        end else if (!bus.PC_write_en || halted_q) begin
            pc_d = pc_q;
        end else if (is_hlt) begin
            halted_d = 1'b1;
        end else begin
            pc_d = pc_plus2;
        end

        // IF/ID is written independently of the PC. A redirect or a halted front end
        // inserts a bubble so that no wrong-path or post-HLT word reaches ID.
        if (bus.IFID_write_en) begin
            if (accept_br || halted_q) begin
                instr_d    = NOP_INSTR;
                pc_plus2_d = 16'h0000;
                valid_d    = 1'b0;
            end else begin
                instr_d    = bus.imem_data;
                pc_plus2_d = pc_plus2;
                valid_d    = 1'b1;
            end
        end

        // Both event counters stick at all-ones instead of wrapping.
        if (!bus.PC_write_en && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (accept_br && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // State register with synchronous reset that clears every field, including the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            pc_plus2_q  <= 16'h0000;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc_plus2_q  <= pc_plus2_d;
            valid_q     <= valid_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.imem_addr     = pc_q;
    assign bus.IFID_instr    = instr_q;
    assign bus.IFID_pc_plus2 = pc_plus2_q;
    assign bus.IFID_valid    = valid_q;
    assign bus.halted        = halted_q;
    assign bus.stall_count   = stall_cnt_q;
    assign bus.flush_count   = flush_cnt_q;

endmodule
